// File: rtl/xadc_scan_pkg.sv
// Shared state encoding, widths and DRP channel address table for the XADC scanner.
package xadc_scan_pkg;

  localparam int unsigned CH_W   = 4;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 7;

  typedef enum logic [2:0] {
    STARTUP   = 3'd0,
    WAIT_EOC  = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    PUBLISH   = 3'd4
  } scan_state_e;

  // ch0 is the dedicated VP/VN pair; ch1..ch12 are the auxiliary inputs.
  localparam logic [ADDR_W-1:0] CH_ADDR [13] = '{
    7'h03, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
    7'h16, 7'h17, 7'h18, 7'h19, 7'h1A, 7'h1B
  };

endpackage

// File: rtl/xadc_drp_read.sv
// Single DRP read transaction: one-cycle den, wait for drdy, abandon after DRP_TIMEOUT cycles.
module xadc_drp_read
  import xadc_scan_pkg::*;
#(
  parameter int unsigned DRP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              drdy,
  output logic              den,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned TW = $clog2(DRP_TIMEOUT + 1);

  logic          pending;
  logic          active;
  logic [TW-1:0] tcnt;

  // The den cycle itself does not accept drdy; waiting starts the cycle after.
  assign active  = pending && !den;
  assign done    = active && drdy;
  assign timeout = active && !drdy && (tcnt == TW'(DRP_TIMEOUT - 1));
  assign data    = rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      den     <= 1'b0;
      daddr   <= '0;
      pending <= 1'b0;
      tcnt    <= '0;
    end else begin
      den <= start;
      if (start) begin
        daddr   <= addr;
        pending <= 1'b1;
        tcnt    <= '0;
      end else if (done || timeout) begin
        pending <= 1'b0;
        tcnt    <= '0;
      end else if (active) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/xadc_channel_scanner.sv
// Round-robin XADC channel sequencer publishing one 12-bit sample per DRP read.
// Define XADC_SCAN_AVG_EN to publish the truncated mean of four reads per channel.
module xadc_channel_scanner
  import xadc_scan_pkg::*;
#(
  parameter int unsigned N_CH           = 13,
  parameter int unsigned STARTUP_CYCLES = 64,
  parameter int unsigned DRP_TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              eoc,
  output logic              den,
  output logic              dwe,
  output logic [ADDR_W-1:0] daddr,
  input  logic [15:0]       do_in,
  input  logic              drdy,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned SCNT_W = $clog2(STARTUP_CYCLES + 1);

  scan_state_e       state, state_nx;
  logic [CH_W-1:0]   ch, ch_nx;
  logic [SCNT_W-1:0] scnt;
  logic              start, rd_done, rd_timeout, last_read, publish;
  logic [DATA_W-1:0] rd_data, pub_data;
  logic              unused_lsbs;

  assign unused_lsbs = ^do_in[3:0];
  assign dwe         = 1'b0;
  assign start       = (state == WAIT_EOC) && enable && eoc;
  assign ch_nx       = (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
  assign publish     = (state == READ_WAIT) && rd_done && last_read;

  xadc_drp_read #(
    .DRP_TIMEOUT(DRP_TIMEOUT)
  ) u_drp_read (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (CH_ADDR[ch]),
    .rd_word (do_in[15:4]),
    .drdy    (drdy),
    .den     (den),
    .daddr   (daddr),
    .data    (rd_data),
    .done    (rd_done),
    .timeout (rd_timeout)
  );

`ifdef XADC_SCAN_AVG_EN
  logic [13:0] acc, sum;
  logic [1:0]  rd_cnt;

  assign sum       = acc + {2'b00, rd_data};
  assign last_read = (rd_cnt == 2'd3);
  assign pub_data  = sum[13:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      rd_cnt <= '0;
    end else if (state == READ_WAIT) begin
      if (rd_done) begin
        if (last_read) begin
          acc    <= '0;
          rd_cnt <= '0;
        end else begin
          acc    <= sum;
          rd_cnt <= rd_cnt + 2'd1;
        end
      end else if (rd_timeout) begin
        acc    <= '0;
        rd_cnt <= '0;
      end
    end
  end
`else
  assign last_read = 1'b1;
  assign pub_data  = rd_data;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      STARTUP:   if (scnt == SCNT_W'(STARTUP_CYCLES - 1)) state_nx = WAIT_EOC;
      WAIT_EOC:  if (start) state_nx = READ_REQ;
      READ_REQ:  state_nx = READ_WAIT;
      READ_WAIT: begin
        if (rd_done)         state_nx = last_read ? PUBLISH : WAIT_EOC;
        else if (rd_timeout) state_nx = WAIT_EOC;
      end
      PUBLISH:   state_nx = WAIT_EOC;
      default:   state_nx = STARTUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= STARTUP;
      ch           <= '0;
      scnt         <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nx;
      busy         <= (state_nx == READ_REQ) || (state_nx == READ_WAIT);
      sample_valid <= publish;
      if (state == STARTUP) scnt <= scnt + SCNT_W'(1);
      if (publish) begin
        sample_ch   <= ch;
        sample_data <= pub_data;
      end
      // A timed-out channel is skipped so one dead input cannot stall the scan.
      if ((state == READ_WAIT) && rd_timeout) begin
        timeout_err <= 1'b1;
        ch          <= ch_nx;
      end
      if (state == PUBLISH) ch <= ch_nx;
    end
  end

endmodule

// File: tb/tb_xadc_channel_scanner.sv
// Directed self-checking bench for xadc_channel_scanner.
module tb_xadc_channel_scanner;

  logic        clk, rst, enable, eoc, drdy;
  logic        den, dwe, sample_valid, busy, timeout_err;
  logic [6:0]  daddr;
  logic [15:0] do_in;
  logic [3:0]  sample_ch;
  logic [11:0] sample_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  xadc_channel_scanner #(
    .N_CH(13),
    .STARTUP_CYCLES(64),
    .DRP_TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .eoc(eoc),
    .den(den), .dwe(dwe), .daddr(daddr), .do_in(do_in), .drdy(drdy),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; enable = 1'b1; eoc = 1'b0; drdy = 1'b0; do_in = 16'hFFFF;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic reset_and_start();
    reset_dut();
    repeat (64) step();
  endtask

  // Pulses eoc, then runs ncyc cycles acting as the DRP and recording what the DUT did.
  task automatic run_read(input bit respond, input int lat, input logic [15:0] data,
                          input int ncyc, input bit eoc_mid, input bit drop_en, input bit early_drdy,
                          output int dens, output logic [6:0] addr, output int svs,
                          output logic [3:0] sch, output logic [11:0] sdat,
                          output int eoc_cyc, output int den_cyc, output int sv_cyc, output int to_cyc);
    bit prev_to;
    dens = 0; svs = 0; addr = '0; sch = '0; sdat = '0;
    den_cyc = -1; sv_cyc = -1; to_cyc = -1;
    prev_to = timeout_err;
    eoc = 1'b1; eoc_cyc = cyc;
    step();
    for (int i = 0; i < ncyc; i++) begin
      eoc = 1'b0; drdy = 1'b0; do_in = 16'hFFFF;
      if (den) begin
        dens++;
        if (den_cyc < 0) begin addr = daddr; den_cyc = cyc; end
      end
      if (sample_valid) begin svs++; sch = sample_ch; sdat = sample_data; sv_cyc = cyc; end
      if (timeout_err && !prev_to) to_cyc = cyc;
      prev_to = timeout_err;
      if (den_cyc >= 0) begin
        if (respond && cyc == den_cyc + lat) begin drdy = 1'b1; do_in = data; end
        if (early_drdy && cyc == den_cyc) begin drdy = 1'b1; do_in = 16'hABC0; end
        if (eoc_mid && cyc == den_cyc + 2) eoc = 1'b1;
        if (drop_en && cyc == den_cyc) enable = 1'b0;
      end
      step();
    end
    eoc = 1'b0; drdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; eoc = 1'b0; drdy = 1'b0; do_in = '0;
    step();
    n_cmp++; if (den !== 1'b0) begin n_err++; $display("FAIL reset_den got=%b exp=0", den); end
    n_cmp++; if (dwe !== 1'b0) begin n_err++; $display("FAIL reset_dwe got=%b exp=0", dwe); end
    n_cmp++; if (daddr !== 7'h00) begin n_err++; $display("FAIL reset_daddr got=%h exp=00", daddr); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_sv got=%b exp=0", sample_valid); end
    n_cmp++; if ({sample_ch, sample_data} !== 16'h0) begin n_err++; $display("FAIL reset_sample got=%h/%h exp=0/0", sample_ch, sample_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_toerr got=%b exp=0", timeout_err); end
  endtask

  task automatic test_startup();
    int first_den = -1;
    int early = 0;
    logic [6:0] a = '0;
    reset_dut();
    for (int i = 0; i <= 75; i++) begin
      if (den && first_den < 0) begin first_den = cyc; a = daddr; end
      if (den && cyc <= 70) early++;
      eoc = (cyc == 10 || cyc == 60 || cyc == 70);
      step();
    end
    eoc = 1'b0;
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL startup_early_den got=%0d exp=0", early); end
    n_cmp++; if (first_den !== 71) begin n_err++; $display("FAIL startup_first_den cycle got=%0d exp=71", first_den); end
    n_cmp++; if (a !== 7'h03) begin n_err++; $display("FAIL startup_daddr got=%h exp=03", a); end
  endtask

  task automatic test_round_robin();
    int dens, svs, ec, dc, sc, tc;
    logic [6:0] a; logic [3:0] sch; logic [11:0] sd;
    logic [3:0] c; logic [6:0] ea;
    reset_and_start();
    for (int i = 0; i < 14; i++) begin
      c  = 4'(i % 13);
      ea = (c == 4'd0) ? 7'h03 : 7'h0F + 7'(c);
      run_read(1'b1, 3, {c, 12'h000}, 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
      n_cmp++; if (dens !== 1) begin n_err++; $display("FAIL rr_den_count i=%0d got=%0d exp=1", i, dens); end
      n_cmp++; if (a !== ea) begin n_err++; $display("FAIL rr_daddr i=%0d got=%h exp=%h", i, a, ea); end
      n_cmp++; if (dc !== ec + 1) begin n_err++; $display("FAIL rr_den_latency i=%0d got=%0d exp=%0d", i, dc, ec + 1); end
      n_cmp++; if (svs !== 1) begin n_err++; $display("FAIL rr_sv_count i=%0d got=%0d exp=1", i, svs); end
      n_cmp++; if (sc !== dc + 4) begin n_err++; $display("FAIL rr_sv_latency i=%0d got=%0d exp=%0d", i, sc, dc + 4); end
      n_cmp++; if (sch !== c) begin n_err++; $display("FAIL rr_ch i=%0d got=%0d exp=%0d", i, sch, c); end
      n_cmp++; if (sd !== {c, 8'h00}) begin n_err++; $display("FAIL rr_data i=%0d got=%h exp=%h", i, sd, {c, 8'h00}); end
    end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rr_toerr got=%b exp=0", timeout_err); end
  endtask

  task automatic test_timeout();
    int dens, svs, ec, dc, sc, tc;
    logic [6:0] a; logic [3:0] sch; logic [11:0] sd;
    reset_and_start();
    for (int i = 0; i < 2; i++)
      run_read(1'b1, 3, 16'h5550, 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    run_read(1'b0, 3, 16'h0, 270, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (a !== 7'h11) begin n_err++; $display("FAIL to_daddr got=%h exp=11", a); end
    n_cmp++; if (svs !== 0) begin n_err++; $display("FAIL to_no_sample got=%0d exp=0", svs); end
    n_cmp++; if (tc !== dc + 256) begin n_err++; $display("FAIL to_rise_cycle got=%0d exp=%0d", tc, dc + 256); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy got=%b exp=0", busy); end
    run_read(1'b1, 3, 16'h7890, 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (a !== 7'h12) begin n_err++; $display("FAIL to_next_daddr got=%h exp=12", a); end
    n_cmp++; if (sch !== 4'd3 || svs !== 1) begin n_err++; $display("FAIL to_next_ch got=%0d/%0d exp=3/1", sch, svs); end
    n_cmp++; if (sd !== 12'h789) begin n_err++; $display("FAIL to_next_data got=%h exp=789", sd); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
  endtask

  task automatic test_boundaries();
    int dens, svs, ec, dc, sc, tc;
    logic [6:0] a; logic [3:0] sch; logic [11:0] sd;
    reset_and_start();
    enable = 1'b0;
    run_read(1'b1, 3, 16'h1230, 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (dens !== 0 || svs !== 0) begin n_err++; $display("FAIL en_low_blocks got=%0d/%0d exp=0/0", dens, svs); end
    enable = 1'b1;
    run_read(1'b1, 3, 16'h2340, 8, 1'b0, 1'b1, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (svs !== 1 || sch !== 4'd0 || sd !== 12'h234) begin n_err++; $display("FAIL en_drop_completes got=%0d/%0d/%h exp=1/0/234", svs, sch, sd); end
    run_read(1'b1, 3, 16'h3450, 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (dens !== 0) begin n_err++; $display("FAIL en_drop_blocks_next got=%0d exp=0", dens); end
    enable = 1'b1;
    run_read(1'b1, 3, 16'h4560, 10, 1'b1, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (dens !== 1) begin n_err++; $display("FAIL eoc_mid_dropped got=%0d exp=1", dens); end
    n_cmp++; if (a !== 7'h10 || sch !== 4'd1) begin n_err++; $display("FAIL eoc_mid_ch got=%h/%0d exp=10/1", a, sch); end
    run_read(1'b1, 2, 16'h5670, 8, 1'b0, 1'b0, 1'b1, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (svs !== 1 || sd !== 12'h567) begin n_err++; $display("FAIL early_drdy_ignored got=%0d/%h exp=1/567", svs, sd); end
  endtask

  task automatic test_back_to_back();
    int last = -100;
    int n = 0;
    int bad = 0;
    reset_and_start();
    eoc = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drdy = (cyc == last + 1);
      do_in = 16'h0010;
      if (den) begin
        if (n > 0 && cyc - last != 4) bad++;
        n++;
        last = cyc;
      end
      step();
    end
    eoc = 1'b0; drdy = 1'b0;
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL b2b_den_count got=%0d exp=8", n); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_spacing bad_gaps got=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid_read();
    int late_sv = 0;
    int late_den = 0;
    reset_and_start();
    eoc = 1'b1; step(); eoc = 1'b0;
    n_cmp++; if (den !== 1'b1) begin n_err++; $display("FAIL rmr_den_issued got=%b exp=1", den); end
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if ({den, busy, sample_valid, timeout_err} !== 4'b0000 || daddr !== 7'h00)
      begin n_err++; $display("FAIL rmr_outputs_cleared got=%b%b%b%b/%h exp=0000/00", den, busy, sample_valid, timeout_err, daddr); end
    step(); step();
    rst = 1'b0; cyc = 0;
    for (int i = 0; i < 12; i++) begin
      drdy = (i < 3); do_in = 16'h9990;
      eoc = (i == 4);
      if (sample_valid) late_sv++;
      if (den) late_den++;
      step();
    end
    drdy = 1'b0; eoc = 1'b0;
    n_cmp++; if (late_sv !== 0) begin n_err++; $display("FAIL rmr_late_drdy got=%0d exp=0", late_sv); end
    n_cmp++; if (late_den !== 0) begin n_err++; $display("FAIL rmr_den_in_startup got=%0d exp=0", late_den); end
  endtask

  task automatic test_average();
    int dens, svs, ec, dc, sc, tc;
    logic [6:0] a; logic [3:0] sch; logic [11:0] sd;
    logic [15:0] vals [4] = '{16'h1000, 16'h1010, 16'h1020, 16'h1040};
    reset_and_start();
    for (int i = 0; i < 4; i++) begin
      run_read(1'b1, 3, vals[i], 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
      n_cmp++; if (a !== 7'h03) begin n_err++; $display("FAIL avg_daddr i=%0d got=%h exp=03", i, a); end
      n_cmp++; if (svs !== ((i == 3) ? 1 : 0)) begin n_err++; $display("FAIL avg_sv i=%0d got=%0d exp=%0d", i, svs, (i == 3) ? 1 : 0); end
    end
    n_cmp++; if (sd !== 12'h101 || sch !== 4'd0) begin n_err++; $display("FAIL avg_result got=%h/%0d exp=101/0", sd, sch); end
    run_read(1'b1, 3, 16'h2000, 8, 1'b0, 1'b0, 1'b0, dens, a, svs, sch, sd, ec, dc, sc, tc);
    n_cmp++; if (a !== 7'h10 || svs !== 0) begin n_err++; $display("FAIL avg_next_ch got=%h/%0d exp=10/0", a, svs); end
  endtask

  initial begin
    test_reset();
`ifdef XADC_SCAN_AVG_EN
    test_average();
`else
    test_startup();
    test_round_robin();
    test_timeout();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_read();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xadc_channel_scanner.md
# xadc_channel_scanner

Round-robin XADC sampling sequencer for the 13-channel voltage instrument. Held in reset by the internal reset generator until the MMCM is locked and the reset pulse has elapsed, then waits a fixed startup interval. After that it reads one channel over the XADC DRP on every end-of-conversion pulse. Each 12-bit result is published with its channel index to the display/conversion logic downstream.

## Interface
- N_CH, 13: number of scanned channels; index width 4 bits.
- STARTUP_CYCLES, 64: clk cycles idled after reset release before the first read.
- DRP_TIMEOUT, 255: clk cycles waited for drdy before a read is abandoned.

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable, sampled in WAIT_EOC.
- eoc  in  1  XADC end-of-conversion, one-cycle pulse.
- den  out  1  DRP enable, one-cycle pulse per read.
- dwe  out  1  DRP write enable, constant 0.
- daddr  out  7  DRP address of the channel being read.
- do_in  in  16  DRP read data; result is do_in[15:4].
- drdy  in  1  DRP data ready, one-cycle pulse.
- sample_valid  out  1  one-cycle strobe: sample_ch/sample_data are valid.
- sample_ch  out  4  channel index 0..N_CH-1.
- sample_data  out  12  conversion result.
- busy  out  1  high in READ_REQ and READ_WAIT.
- timeout_err  out  1  sticky; set on any DRP timeout, cleared only by rst.

## Operation
- States: STARTUP, WAIT_EOC, READ_REQ, READ_WAIT, PUBLISH.
- Reset values: state=STARTUP, ch=0, all outputs 0, daddr=0, accumulator 0.
- STARTUP:
  - counts STARTUP_CYCLES cycles, then enters WAIT_EOC.
  - eoc is ignored in this state.
- WAIT_EOC: when enable=1 and eoc=1, go to READ_REQ. Otherwise stay.
- READ_REQ:
  - den=1 for exactly one cycle, daddr=CH_ADDR[ch].
  - next state is READ_WAIT; timeout counter is cleared.
- READ_WAIT:
  - on drdy, capture do_in[15:4] and go to PUBLISH.
  - if DRP_TIMEOUT cycles pass without drdy: set timeout_err, advance ch, return to WAIT_EOC, publish nothing.
- PUBLISH:
  - sample_valid=1 for one cycle with sample_ch=ch.
  - ch advances; N_CH-1 wraps to 0. Return to WAIT_EOC.
- daddr holds its last value outside READ_REQ. dwe is never asserted.
- Boundary cases:
  - eoc outside WAIT_EOC is dropped, not queued.
  - drdy outside READ_WAIT is ignored.
  - enable falling mid-read lets the read complete and publish; the next read is then blocked.
  - rst asserted mid-read aborts immediately. The next den is issued only after STARTUP completes again.

## Timing
- eoc sampled at cycle n → den high at cycle n+1.
- drdy sampled at cycle m → sample_valid high at cycle m+1.
- Minimum spacing between two den pulses: 4 cycles.
- Timeout: den at cycle k with no drdy → timeout_err high at cycle k+DRP_TIMEOUT+1.
- All outputs are registered.

## Configuration
- XADC_SCAN_AVG_EN defined:
  - each channel is read 4 times; ch advances only after the 4th read.
  - results sum into a 14-bit accumulator; the 4th read publishes sum[13:2] (truncating).
  - the accumulator clears on publish, on timeout and on rst.
  - a timeout discards the partial sum and advances ch.
- Undefined: every read is published directly; no accumulator is instantiated.

## Structure
- Package xadc_scan_pkg holds:
  - state enumeration;
  - CH_ADDR constant table: ch0=0x03 (VP/VN), ch1..ch12=0x10..0x1B;
  - width constants CH_W=4, DATA_W=12, ADDR_W=7.
- One sub-module, xadc_drp_read: issues den/daddr, waits for drdy, runs the timeout counter. It returns data plus done/timeout pulses to the scanner FSM.

## Test plan
- Startup: release rst, pulse eoc at cycles 10 and 70 → no den before cycle 64+; first den follows the eoc at cycle 70 with daddr=0x03.
- Round robin: model drdy 3 cycles after den with do_in=ch<<8<<4, 14 eocs → sample_ch 0..12 then 0; sample_data=ch<<8; daddr=0x10 for ch1.
- Timeout: suppress drdy for ch2 → timeout_err rises DRP_TIMEOUT+1 cycles after den, no sample_valid for ch2, next eoc reads ch3 (daddr=0x12).
- Dropped eoc and enable: eoc pulse during READ_WAIT → exactly one den; enable=0 before eoc → no den.
- Reset mid-read: assert rst one cycle after den → all outputs 0 immediately; a late drdy produces no sample_valid.
- Averaging (XADC_SCAN_AVG_EN): ch0 reads 0x100, 0x101, 0x102, 0x104 → single sample_valid with data 0x101 after the 4th drdy; ch stays 0 until then.
